// File: rtl/ysyx_22041412_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22041412_mdu_ctrl
//  Purpose  : Upstream sequencer for the RV64 M-extension multiply/divide unit.
//             Accepts an op from EXU, converts operands to unsigned magnitudes
//             (word-sized for *W ops), issues a one-cycle strobe to the unit,
//             waits LAT cycles, then applies the sign fix-up and the W-result
//             sign extension. Divide-by-zero and signed overflow are resolved
//             locally without touching the unit.
//  Ports    : clk, rst_n                 clock / synchronous active-low reset
//             in_valid_i/in_ready_o      op handshake from EXU
//             in_func3_i, in_word_i      RV funct3 and *W flag
//             in_rs1_i, in_rs2_i         source operands
//             mul_en_o, mul_a_o,
//             mul_b_o, mul_func3_o       issue interface to the unit
//             mul_data_i                 unit result (LAT cycles after issue)
//             out_valid_o/out_ready_i    result handshake to EXU/WBU
//             out_data_o, out_illegal_o  final result and illegal-op flag
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22041412_mdu_ctrl #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  in_func3_i,
    input  logic        in_word_i,
    input  logic [63:0] in_rs1_i,
    input  logic [63:0] in_rs2_i,
    output logic        mul_en_o,
    output logic [63:0] mul_a_o,
    output logic [63:0] mul_b_o,
    output logic [2:0]  mul_func3_o,
    input  logic [63:0] mul_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] out_data_o,
    output logic        out_illegal_o
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               mul_en_q;
    logic [63:0]        mul_a_q;
    logic [63:0]        mul_b_q;
    logic [2:0]         mul_func3_q;
    logic [63:0]        out_data_q;
    logic               out_illegal_q;
    logic               neg_q;
    logic               word_q;
    logic [CNT_W-1:0]   cnt_q;

    // ------------------------------------------------------------------
    // Operand preparation (combinational, evaluated on the accept cycle)
    // ------------------------------------------------------------------
    logic        is_signed, is_div, is_rem, is_quot, is_illegal;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, a_min;
    logic        sign_a, sign_b, div_zero, sgn_ovf, is_special, neg_d;
    logic [63:0] special_res_d;
    logic [2:0]  unit_func3_d;
    logic [63:0] post_neg, post_res_d;

    function automatic logic [63:0] word_fix(input logic [63:0] r, input logic w);
        word_fix = w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    assign is_signed  = (in_func3_i == 3'b100) || (in_func3_i == 3'b110);
    assign is_div     = in_func3_i[2];
    assign is_rem     = in_func3_i[2] & in_func3_i[1];
    assign is_quot    = in_func3_i[2] & ~in_func3_i[1];
    assign is_illegal = ~in_func3_i[2] & (in_func3_i[1:0] != 2'b00);

    // W ops: sign-extend for signed div/rem, zero-extend otherwise (MUL low
    // 32 bits do not depend on the upper operand bits).
    assign a_ext = in_word_i ? {{32{is_signed & in_rs1_i[31]}}, in_rs1_i[31:0]} : in_rs1_i;
    assign b_ext = in_word_i ? {{32{is_signed & in_rs2_i[31]}}, in_rs2_i[31:0]} : in_rs2_i;

    assign sign_a = is_signed & a_ext[63];
    assign sign_b = is_signed & b_ext[63];
    assign a_mag  = sign_a ? (64'd0 - a_ext) : a_ext;
    assign b_mag  = sign_b ? (64'd0 - b_ext) : b_ext;

    // Most negative value as it appears after W sign extension.
    assign a_min      = in_word_i ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign div_zero   = is_div & (b_ext == 64'd0);
    assign sgn_ovf    = is_signed & (a_ext == a_min) & (b_ext == {64{1'b1}});
    assign is_special = div_zero | sgn_ovf;

    always_comb begin
        special_res_d = 64'd0;
        if (div_zero) begin
            special_res_d = is_rem ? a_ext : {64{1'b1}};
        end else if (sgn_ovf) begin
            special_res_d = is_rem ? 64'd0 : a_ext;
        end
    end

    assign neg_d        = is_rem ? sign_a : (is_quot & (sign_a ^ sign_b));
    assign unit_func3_d = {in_func3_i[2], in_func3_i[1] & in_func3_i[2], 1'b0};

    // Fix-up of the unit's unsigned result.
    assign post_neg   = neg_q ? (64'd0 - mul_data_i) : mul_data_i;
    assign post_res_d = word_fix(post_neg, word_q);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mul_en_q      <= 1'b0;
            mul_a_q       <= 64'd0;
            mul_b_q       <= 64'd0;
            mul_func3_q   <= 3'b000;
            out_data_q    <= 64'd0;
            out_illegal_q <= 1'b0;
            neg_q         <= 1'b0;
            word_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        out_illegal_q <= is_illegal;
                        neg_q         <= neg_d;
                        word_q        <= in_word_i;
                        if (is_illegal) begin
                            out_data_q <= 64'd0;
                            state_q    <= S_DONE;
                        end else if (is_special) begin
                            out_data_q <= word_fix(special_res_d, in_word_i);
                            state_q    <= S_DONE;
                        end else begin
                            // Strobe goes high for the ISSUE cycle only.
                            mul_en_q    <= 1'b1;
                            mul_a_q     <= a_mag;
                            mul_b_q     <= b_mag;
                            mul_func3_q <= unit_func3_d;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    mul_en_q <= 1'b0;
                    cnt_q    <= CNT_W'(LAT - 1);
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        out_data_q  <= post_res_d;
                        mul_a_q     <= 64'd0;
                        mul_b_q     <= 64'd0;
                        mul_func3_q <= 3'b000;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o    = (state_q == S_IDLE);
    assign out_valid_o   = (state_q == S_DONE);
    assign mul_en_o      = mul_en_q;
    assign mul_a_o       = mul_a_q;
    assign mul_b_o       = mul_b_q;
    assign mul_func3_o   = mul_func3_q;
    assign out_data_o    = out_data_q;
    assign out_illegal_o = out_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041412_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22041412_mdu_ctrl
//  Purpose  : Self-checking bench for ysyx_22041412_mdu_ctrl. Directed cases
//             followed by random ops, each checked against a RISC-V arithmetic
//             reference model. A behavioural multiply/divide unit with a
//             one-cycle registered result sits behind the controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22041412_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_func3;
    logic        in_word;
    logic [63:0] in_rs1, in_rs2;
    logic        mul_en;
    logic [63:0] mul_a, mul_b;
    logic [2:0]  mul_func3;
    logic [63:0] mul_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    // Issue monitor
    int          en_cnt;
    logic [63:0] cap_a, cap_b;
    logic [2:0]  cap_f;

    always #5 clk = ~clk;

    ysyx_22041412_mdu_ctrl #(.LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_func3_i   (in_func3),
        .in_word_i    (in_word),
        .in_rs1_i     (in_rs1),
        .in_rs2_i     (in_rs2),
        .mul_en_o     (mul_en),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_func3_o  (mul_func3),
        .mul_data_i   (mul_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_illegal_o(out_illegal)
    );

    // Behavioural unit: result registered on the edge that samples en.
    always @(posedge clk) begin
        if (mul_en) begin
            case (mul_func3)
                3'b000:  mul_data <= mul_a * mul_b;
                3'b100:  mul_data <= (mul_b == 64'd0) ? {64{1'b1}} : mul_a / mul_b;
                3'b110:  mul_data <= (mul_b == 64'd0) ? mul_a : mul_a % mul_b;
                default: mul_data <= 64'hDEAD_BEEF_DEAD_BEEF;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mul_en) begin
            en_cnt = en_cnt + 1;
            cap_a  = mul_a;
            cap_b  = mul_b;
            cap_f  = mul_func3;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        sx32 = {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] mag(input longint v);
        mag = (v < 0) ? 64'(-v) : 64'(v);
    endfunction

    // Reference: RISC-V M-extension semantics plus the expected unit traffic.
    task automatic model(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output logic ill, output logic iss,
                         output logic [63:0] ua, output logic [63:0] ub, output logic [2:0] uf);
        longint      sa, sb, smin;
        logic [63:0] xa, xb;
        r = 64'd0; ill = 1'b0; iss = 1'b0; ua = 64'd0; ub = 64'd0; uf = 3'b000;
        sa   = w ? longint'($signed(a[31:0])) : longint'(a);
        sb   = w ? longint'($signed(b[31:0])) : longint'(b);
        xa   = w ? {32'd0, a[31:0]} : a;
        xb   = w ? {32'd0, b[31:0]} : b;
        smin = w ? -64'sd2147483648 : longint'(64'h8000_0000_0000_0000);
        case (f3)
            3'b000: begin r = xa * xb; iss = 1; ua = xa; ub = xb; uf = 3'b000; end
            3'b100: begin
                if (sb == 0) r = {64{1'b1}};
                else if (sa == smin && sb == -1) r = 64'(sa);
                else begin r = 64'(sa / sb); iss = 1; ua = mag(sa); ub = mag(sb); uf = 3'b100; end
            end
            3'b101: begin
                if (xb == 0) r = {64{1'b1}};
                else begin r = xa / xb; iss = 1; ua = xa; ub = xb; uf = 3'b100; end
            end
            3'b110: begin
                if (sb == 0) r = 64'(sa);
                else if (sa == smin && sb == -1) r = 64'd0;
                else begin r = 64'(sa % sb); iss = 1; ua = mag(sa); ub = mag(sb); uf = 3'b110; end
            end
            3'b111: begin
                if (xb == 0) r = xa;
                else begin r = xa % xb; iss = 1; ua = xa; ub = xb; uf = 3'b110; end
            end
            default: ill = 1'b1;
        endcase
        if (w && !ill) r = sx32(r[31:0]);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] er, ua, ub;
        logic        eill, eiss, v, stable;
        logic [2:0]  uf;
        int          n;
        model(f3, w, a, b, er, eill, eiss, ua, ub, uf);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_func3 = f3; in_word = w; in_rs1 = a; in_rs2 = b;
        out_ready = 1'b0; en_cnt = 0;
        @(posedge clk);                       // accept edge k
        #1 in_valid = 1'b0;
        n = 0; v = 1'b0;
        while (!v && n < 20) begin
            @(negedge clk); v = out_valid;
            @(posedge clk); n++;
        end
        check("latency", 64'(n), eiss ? 64'd3 : 64'd1);
        @(negedge clk);
        check("out_data", out_data, er);
        check("out_illegal", out_illegal, eill);
        check("in_ready_done", in_ready, 1'b0);
        check("en_pulses", 64'(en_cnt), eiss ? 64'd1 : 64'd0);
        if (eiss) begin
            check("mul_a", cap_a, ua);
            check("mul_b", cap_b, ub);
            check("mul_func3", cap_f, uf);
        end
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== er || in_ready !== 1'b0) stable = 1'b0;
        end
        check("hold_stable", stable, 1'b1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("release_valid", out_valid, 1'b0);
        check("release_ready", in_ready, 1'b1);
        check("idle_mul_a", mul_a, 64'd0);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       pick = 64'd0;
            1:       pick = {64{1'b1}};
            2:       pick = 64'h8000_0000_0000_0000;
            3:       pick = {$urandom, 32'h8000_0000};
            4:       pick = 64'($urandom_range(0, 40)) - 64'd20;
            default: pick = {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_func3 = 3'b000; in_word = 1'b0;
        in_rs1 = 64'd0; in_rs2 = 64'd0; out_ready = 1'b0; mul_data = 64'd0; en_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_mul_en", mul_en, 1'b0);
        check("rst_mul_a", mul_a, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_illegal", out_illegal, 1'b0);
        rst_n = 1'b1;

        // Directed cases
        run_op(3'b000, 1'b0, 64'd7, -64'd3, 0);
        run_op(3'b100, 1'b0, -64'd20, 64'd3, 1);
        run_op(3'b110, 1'b0, -64'd20, 64'd3, 0);
        run_op(3'b101, 1'b0, 64'd5, 64'd0, 0);
        run_op(3'b111, 1'b0, 64'd5, 64'd0, 0);
        run_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op(3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 0);
        run_op(3'b100, 1'b0, 64'd9, 64'd2, 4);
        run_op(3'b001, 1'b0, 64'd9, 64'd2, 0);

        // Reset while waiting on the unit
        @(negedge clk);
        in_valid = 1'b1; in_func3 = 3'b100; in_word = 1'b0; in_rs1 = 64'd100; in_rs2 = 64'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready, 1'b1);
        check("mid_rst_mul_en", mul_en, 1'b0);
        check("mid_rst_out_data", out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b011, 1'b1, 64'd1, 64'd1, 0);

        // Random ops
        for (int t = 0; t < 60; t++) begin
            run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
